// File: rtl/fir_sequencer.sv
// fir_sequencer: self-sequenced FIR engine, one multiply-accumulate per clock.
// Latency: TAPS+1 cycles from input acceptance to out_valid; one sample per TAPS+3 cycles at best.
// Backpressure: in_ready only in IDLE; the result holds in OUT until out_ready.
// Optional FIR_SEQ_SAT_EN: clamp the scaled result to the DATA_W range instead of wrapping.
module fir_sequencer #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 64,
  parameter int ACC_W     = 40,
  parameter int OUT_SHIFT = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [DATA_W-1:0]   out_data,
  output logic                       busy
);

  localparam int AW = $clog2(TAPS);
  localparam int PW = DATA_W + COEF_W;
  localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);
  // TAPS modulo 2^AW: zero for power-of-two depths, so the wrap add is correct either way
  localparam logic [AW-1:0] TAPS_MOD = AW'(TAPS);

  typedef enum logic [1:0] {IDLE, MAC, DONE, OUT} state_t;

  state_t                     state_q, state_d;
  logic signed [COEF_W-1:0]   coef_q [TAPS];
  logic signed [COEF_W-1:0]   coef_d [TAPS];
  logic signed [DATA_W-1:0]   hist_q [TAPS];
  logic signed [DATA_W-1:0]   hist_d [TAPS];
  logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]              k_q, k_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic                       out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0]   out_data_q, out_data_d;

  logic [AW-1:0]              rd_idx;
  logic signed [PW-1:0]       prod;
  logic signed [DATA_W-1:0]   scaled_out;

  // History read index: newest sample minus tap number, modulo TAPS
  always_comb begin
    rd_idx = '0;
    if (wr_ptr_q >= k_q) rd_idx = wr_ptr_q - k_q;
    else                 rd_idx = wr_ptr_q + TAPS_MOD - k_q;
    prod = coef_q[k_q] * hist_q[rd_idx];
  end

`ifdef FIR_SEQ_SAT_EN
  localparam logic signed [DATA_W-1:0] D_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] D_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  logic signed [ACC_W-1:0] scaled;

  // Scale the accumulator and clamp to the representable output range
  always_comb begin
    scaled     = acc_q >>> OUT_SHIFT;
    scaled_out = scaled[DATA_W-1:0];
    if (scaled > ACC_W'(D_MAX))      scaled_out = D_MAX;
    else if (scaled < ACC_W'(D_MIN)) scaled_out = D_MIN;
  end
`else
  // Scale the accumulator and keep the low bits (two's-complement wrap)
  always_comb begin
    scaled_out = DATA_W'(acc_q >>> OUT_SHIFT);
  end
`endif

  // Next-state and datapath updates for the IDLE/MAC/DONE/OUT sequence
  always_comb begin
    state_d     = state_q;
    coef_d      = coef_q;
    hist_d      = hist_q;
    wr_ptr_d    = wr_ptr_q;
    k_d         = k_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE: begin
        // Coefficient write lands on the same edge as a sample, so that sample sees it
        if (coef_we && ({1'b0, coef_addr} < (AW+1)'(TAPS))) coef_d[coef_addr] = coef_data;
        if (in_valid) begin
          hist_d[wr_ptr_q] = in_data;
          acc_d            = '0;
          k_d              = '0;
          state_d          = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + ACC_W'(prod);
        if (k_q == LAST_TAP) begin
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        out_data_d  = scaled_out;
        out_valid_d = 1'b1;
        wr_ptr_d    = (wr_ptr_q == LAST_TAP) ? '0 : wr_ptr_q + 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset clears coefficients and history as well
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < TAPS; i++) begin
        coef_q[i] <= '0;
        hist_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      for (int i = 0; i < TAPS; i++) begin
        coef_q[i] <= coef_d[i];
        hist_q[i] <= hist_d[i];
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
